bnn_seq_hs: RTL and testbench
=============================

# bnn_seq_hs

Sequential binarised neural network (one binary hidden layer, one XNOR-popcount output layer) with valid/ready handshakes on input and output. It succeeds the free-running sequential BNN core. It adds a configurable hidden-layer parallelism, a registered winning score next to the prediction, output backpressure and a deterministic argmax tie-break. Per-dataset wrappers instantiate it with their own weight constants.

## Interface
Parameters:
- FEAT_CNT, 128, number of input features
- FEAT_BITS, 4, unsigned bits per feature
- HIDDEN_CNT, 40, number of hidden neurons
- CLASS_CNT, 6, number of output classes
- PAR_H, 8, hidden neurons evaluated per cycle (1..HIDDEN_CNT)
- Weights0, 0, HIDDEN_CNT*FEAT_CNT bits; bit [h*FEAT_CNT+f] is the weight for hidden neuron h, feature f
- Weights1, 0, CLASS_CNT*HIDDEN_CNT bits; bit [c*HIDDEN_CNT+h] is the weight for class c, hidden neuron h

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- features  in  FEAT_CNT*FEAT_BITS  feature f at [f*FEAT_BITS +: FEAT_BITS]
- in_valid  in  1  the features bus is valid
- in_ready  out  1  block can accept features
- prediction  out  $clog2(CLASS_CNT)  winning class index
- score  out  $clog2(HIDDEN_CNT+1)  popcount of the winning class
- out_valid  out  1  prediction and score are valid
- out_ready  in  1  consumer accepts the result

## Operation
- States: IDLE, L0, L1, HOLD.
- IDLE:
  - in_ready=1.
  - When in_valid is high, capture features into a register and go to L0.
- L0: hidden-layer evaluation.
  - Evaluates PAR_H hidden neurons per cycle over N0=ceil(HIDDEN_CNT/PAR_H) cycles.
  - Each neuron forms a signed sum of +x_f where the weight bit is 1 and −x_f where it is 0.
  - Sum width is FEAT_BITS+$clog2(FEAT_CNT)+1. The sum cannot overflow.
  - Hidden bit = (sum ≥ 0). A zero sum gives 1.
  - In the last group, lanes with index ≥ HIDDEN_CNT are ignored.
  - Hidden bits are stored in a HIDDEN_CNT-bit register.
- L1: output-layer evaluation.
  - Evaluates one class per cycle, c = 0..CLASS_CNT−1.
  - Class score = popcount(XNOR(hidden, Weights1 row c)).
  - Running argmax: a class replaces the current best only on a strictly greater score, so ties go to the lowest index.
  - After the last class, register prediction and score, set out_valid=1 and go to HOLD.
- HOLD:
  - out_valid=1. prediction and score stay stable until out_ready is high.
  - On out_ready: out_valid=0 on the next cycle, go to IDLE.
- in_ready is 1 only in IDLE. in_valid is ignored in every other state.
- Reset:
  - state=IDLE, in_ready=1, out_valid=0, prediction=0, score=0, internal counters 0.
  - A reset during L0, L1 or HOLD aborts the inference. No result is produced.

## Timing
- The accept edge is the rising edge where in_valid && in_ready.
- L0 occupies the N0 cycles after the accept edge. L1 occupies the next CLASS_CNT cycles.
- out_valid rises N0+CLASS_CNT+1 cycles after the accept edge. With the defaults: 5+6+1=12.
- The output handshake completes on the edge where out_valid && out_ready.
- in_ready is high in the cycle after the output handshake.
- Minimum spacing between accepts is N0+CLASS_CNT+3 cycles when out_ready is held high.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- features is sampled only at the accept edge. Later changes to the bus have no effect.

## Structure
- Package bnn_pkg holds the width helper functions for sum width, score width and N0, shared by all BNN cores.
- Sub-module bnn_l0_neuron: combinational signed weighted sum of FEAT_CNT features for one weight row, with hidden-bit output. The core instantiates PAR_H of them.
- The L0 row select is a counter-indexed slice of Weights0.

## Test plan
Small configuration for tests 1–4: FEAT_CNT=4, HIDDEN_CNT=4, CLASS_CNT=3, PAR_H=2.

1. Weights0 all 1s; Weights1 rows c0=0011, c1=1111, c2=1111; features=any.
   -> Hidden bits 1111, scores 2/4/4.
   -> prediction=1 (tie goes to the lowest index), score=4, out_valid 6 cycles after accept.
2. Weights0 all 0s, feature0=5, other features 0; Weights1 rows c0=0000, c1=1111, c2=0101.
   -> Hidden bits 0000. prediction=0, score=4.
3. Test 1 setup, with out_ready held low 10 cycles after out_valid, and in_valid pulsed during the hold.
   -> prediction and score are stable, in_ready=0, the new input is not accepted.
   -> After out_ready: in_ready=1 in the next cycle.
4. rst asserted in the 2nd L0 cycle.
   -> out_valid never rises, in_ready=1 in the cycle after reset.
   -> A subsequent inference is correct.
5. PAR_H=3 with HIDDEN_CNT=4 (non-dividing).
   -> Same results as test 1, with out_valid 6 cycles after accept (N0=2).
6. Default 128/40/6 configuration, PAR_H in {1, 8, 40}, 1000 random feature vectors with random out_ready.
   -> Prediction and score match the reference model every time, with latency N0+7.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the sequential BNN cores.
package bnn_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_L0   = 2'd1,
        S_L1   = 2'd2,
        S_HOLD = 2'd3
    } bnn_state_e;

    // Signed hidden-neuron sum: one sign bit on top of the largest magnitude.
    function automatic int sum_width(input int feat_bits, input int feat_cnt);
        return feat_bits + $clog2(feat_cnt) + 1;
    endfunction

    function automatic int score_width(input int hidden_cnt);
        return $clog2(hidden_cnt + 1);
    endfunction

    function automatic int n0_cycles(input int hidden_cnt, input int par_h);
        return (hidden_cnt + par_h - 1) / par_h;
    endfunction

endpackage

// File: rtl/bnn_l0_neuron.sv
// One binary hidden neuron: signed +/- feature sum for a weight row, thresholded at zero.
module bnn_l0_neuron
    import bnn_pkg::*;
#(
    parameter int FEAT_CNT  = 128,
    parameter int FEAT_BITS = 4
) (
    input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
    input  logic [FEAT_CNT-1:0]           weights,
    output logic                          hidden_bit
);

    localparam int SUM_W = sum_width(FEAT_BITS, FEAT_CNT);

    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] x_s;

    // Weight 1 adds the feature, weight 0 subtracts it.
    always_comb begin
        sum_s = {SUM_W{1'b0}};
        x_s   = {SUM_W{1'b0}};
        for (int f = 0; f < FEAT_CNT; f++) begin
            x_s = SUM_W'(features[f*FEAT_BITS +: FEAT_BITS]);
            if (weights[f]) begin
                sum_s = sum_s + x_s;
            end else begin
                sum_s = sum_s - x_s;
            end
        end
    end

    assign hidden_bit = ~sum_s[SUM_W-1];

endmodule

// File: rtl/bnn_seq_hs.sv
// Sequential BNN core: PAR_H hidden neurons per cycle, one output class per cycle,
// valid/ready on both sides with the winning class and score held until accepted.
module bnn_seq_hs
    import bnn_pkg::*;
#(
    parameter int FEAT_CNT   = 128,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 6,
    parameter int PAR_H      = 8,
    parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  Weights0 = '0,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] Weights1 = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FEAT_CNT*FEAT_BITS-1:0]     features,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [$clog2(CLASS_CNT)-1:0]      prediction,
    output logic [$clog2(HIDDEN_CNT+1)-1:0]   score,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int N0       = n0_cycles(HIDDEN_CNT, PAR_H);
    localparam int SW       = score_width(HIDDEN_CNT);
    localparam int PW       = $clog2(CLASS_CNT);
    localparam int GW       = (N0 > 1) ? $clog2(N0) : 1;
    localparam int FW       = FEAT_CNT * FEAT_BITS;
    localparam int W0_PAD_W = N0 * PAR_H * FEAT_CNT;
    localparam int W0_IW    = $clog2(W0_PAD_W);
    localparam int W1_IW    = $clog2(CLASS_CNT * HIDDEN_CNT);

    // Zero rows past HIDDEN_CNT keep the last group's slice in range; those lanes are never stored.
    localparam logic [W0_PAD_W-1:0] W0_PAD = W0_PAD_W'(Weights0);

    bnn_state_e            state_q, state_d;
    logic [FW-1:0]         feat_q, feat_d;
    logic [GW-1:0]         grp_q, grp_d;
    logic [PW-1:0]         cls_q, cls_d;
    logic [HIDDEN_CNT-1:0] hidden_q, hidden_d;
    logic [PW-1:0]         best_idx_q, best_idx_d;
    logic [SW-1:0]         best_score_q, best_score_d;
    logic [PW-1:0]         pred_q, pred_d;
    logic [SW-1:0]         score_q, score_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d;

    logic [PAR_H-1:0]      lane_bits_s;
    logic [W1_IW-1:0]      w1_base_s;
    logic [HIDDEN_CNT-1:0] w1_row_s;
    logic [SW-1:0]         cls_score_s;

    function automatic logic [SW-1:0] popcount(input logic [HIDDEN_CNT-1:0] v);
        logic [SW-1:0] cnt;
        cnt = {SW{1'b0}};
        for (int i = 0; i < HIDDEN_CNT; i++) begin
            cnt = cnt + SW'(v[i]);
        end
        return cnt;
    endfunction

    for (genvar p = 0; p < PAR_H; p++) begin : g_lane
        logic [W0_IW-1:0]    base_s;
        logic [FEAT_CNT-1:0] row_s;

        assign base_s = W0_IW'((int'(grp_q) * PAR_H + p) * FEAT_CNT);
        assign row_s  = W0_PAD[base_s +: FEAT_CNT];

        bnn_l0_neuron #(
            .FEAT_CNT  (FEAT_CNT),
            .FEAT_BITS (FEAT_BITS)
        ) u_neuron (
            .features   (feat_q),
            .weights    (row_s),
            .hidden_bit (lane_bits_s[p])
        );
    end

    assign w1_base_s   = W1_IW'(int'(cls_q) * HIDDEN_CNT);
    assign w1_row_s    = Weights1[w1_base_s +: HIDDEN_CNT];
    assign cls_score_s = popcount(~(hidden_q ^ w1_row_s));

    // Next-state and datapath for the IDLE -> L0 -> L1 -> HOLD sequence.
    always_comb begin
        state_d      = state_q;
        feat_d       = feat_q;
        grp_d        = grp_q;
        cls_d        = cls_q;
        hidden_d     = hidden_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        pred_d       = pred_q;
        score_d      = score_q;
        out_valid_d  = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    feat_d       = features;
                    grp_d        = {GW{1'b0}};
                    cls_d        = {PW{1'b0}};
                    best_idx_d   = {PW{1'b0}};
                    best_score_d = {SW{1'b0}};
                    state_d      = S_L0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_L0: begin
                for (int h = 0; h < HIDDEN_CNT; h++) begin
                    if (GW'(h / PAR_H) == grp_q) begin
                        hidden_d[h] = lane_bits_s[h % PAR_H];
                    end else begin
                        hidden_d[h] = hidden_q[h];
                    end
                end
                if (grp_q == GW'(N0 - 1)) begin
                    grp_d   = {GW{1'b0}};
                    state_d = S_L1;
                end else begin
                    grp_d = grp_q + GW'(1);
                end
            end
            S_L1: begin
                // Strictly greater: equal scores keep the lower class index.
                if (cls_score_s > best_score_q) begin
                    best_idx_d   = cls_q;
                    best_score_d = cls_score_s;
                end else begin
                    best_idx_d = best_idx_q;
                end
                if (cls_q == PW'(CLASS_CNT - 1)) begin
                    cls_d   = {PW{1'b0}};
                    state_d = S_HOLD;
                end else begin
                    cls_d = cls_q + PW'(1);
                end
            end
            S_HOLD: begin
                if (!out_valid_q) begin
                    pred_d      = best_idx_q;
                    score_d     = best_score_q;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            feat_q       <= {FW{1'b0}};
            grp_q        <= {GW{1'b0}};
            cls_q        <= {PW{1'b0}};
            hidden_q     <= {HIDDEN_CNT{1'b0}};
            best_idx_q   <= {PW{1'b0}};
            best_score_q <= {SW{1'b0}};
            pred_q       <= {PW{1'b0}};
            score_q      <= {SW{1'b0}};
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            feat_q       <= feat_d;
            grp_q        <= grp_d;
            cls_q        <= cls_d;
            hidden_q     <= hidden_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            pred_q       <= pred_d;
            score_q      <= score_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign prediction = pred_q;
    assign score      = score_q;

endmodule

// File: tb/tb_bnn_seq_hs.sv
// Bench for bnn_seq_hs: directed small-configuration scenarios plus randomized
// default-configuration runs at three hidden-layer parallelisms against a reference model.
module tb_bnn_seq_hs;

    localparam int B_FEAT = 128;
    localparam int B_HID  = 40;
    localparam int B_CLS  = 6;
    localparam int B_FW   = B_FEAT * 4;
    localparam int N_VEC  = 1000;

    function automatic logic [31:0] xs(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic logic [B_HID*B_FEAT-1:0] gen_w0();
        logic [B_HID*B_FEAT-1:0] r;
        logic [31:0] st;
        r  = '0;
        st = 32'h2545_F491;
        for (int h = 0; h < B_HID; h++) begin
            for (int f = 0; f < B_FEAT; f++) begin
                st = xs(st);
                r[h*B_FEAT + f] = st[7];
            end
        end
        return r;
    endfunction

    function automatic logic [B_CLS*B_HID-1:0] gen_w1();
        logic [B_CLS*B_HID-1:0] r;
        logic [31:0] st;
        r  = '0;
        st = 32'h9E37_79B9;
        for (int c = 0; c < B_CLS; c++) begin
            for (int h = 0; h < B_HID; h++) begin
                st = xs(st);
                r[c*B_HID + h] = st[11];
            end
        end
        return r;
    endfunction

    localparam logic [B_HID*B_FEAT-1:0] B_W0 = gen_w0();
    localparam logic [B_CLS*B_HID-1:0]  B_W1 = gen_w1();
    localparam logic [2:0][15:0] S_W0  = {16'hFFFF, 16'h0000, 16'hFFFF};
    localparam logic [2:0][11:0] S_W1  = {12'hFF3, 12'h5F0, 12'hFF3};
    localparam logic [2:0][7:0]  S_PAR = {8'd3, 8'd2, 8'd2};
    localparam logic [2:0][7:0]  B_PAR = {8'd40, 8'd8, 8'd1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [2:0][15:0] s_feat;
    logic [2:0]       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [2:0][1:0]  s_pred;
    logic [2:0][2:0]  s_score;

    logic [2:0][B_FW-1:0] b_feat;
    logic [2:0]           b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [2:0][2:0]      b_pred;
    logic [2:0][5:0]      b_score;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_small
        bnn_seq_hs #(
            .FEAT_CNT(4), .FEAT_BITS(4), .HIDDEN_CNT(4), .CLASS_CNT(3),
            .PAR_H(int'(S_PAR[k])), .Weights0(S_W0[k]), .Weights1(S_W1[k])
        ) u_dut (
            .clk(clk), .rst(rst), .features(s_feat[k]),
            .in_valid(s_in_valid[k]), .in_ready(s_in_ready[k]),
            .prediction(s_pred[k]), .score(s_score[k]),
            .out_valid(s_out_valid[k]), .out_ready(s_out_ready[k])
        );
    end

    for (genvar k = 0; k < 3; k++) begin : g_big
        bnn_seq_hs #(
            .FEAT_CNT(B_FEAT), .FEAT_BITS(4), .HIDDEN_CNT(B_HID), .CLASS_CNT(B_CLS),
            .PAR_H(int'(B_PAR[k])), .Weights0(B_W0), .Weights1(B_W1)
        ) u_dut (
            .clk(clk), .rst(rst), .features(b_feat[k]),
            .in_valid(b_in_valid[k]), .in_ready(b_in_ready[k]),
            .prediction(b_pred[k]), .score(b_score[k]),
            .out_valid(b_out_valid[k]), .out_ready(b_out_ready[k])
        );
    end

    // Reference: plain integer sums and counts straight from the network definition.
    function automatic void ref_model(input logic [B_FW-1:0] f, output int pred, output int scr);
        bit hid [B_HID];
        int s, x, cnt, best;
        for (int h = 0; h < B_HID; h++) begin
            s = 0;
            for (int i = 0; i < B_FEAT; i++) begin
                x = int'(f[i*4 +: 4]);
                if (B_W0[h*B_FEAT + i]) s = s + x;
                else                    s = s - x;
            end
            hid[h] = (s >= 0);
        end
        best = -1;
        pred = 0;
        for (int c = 0; c < B_CLS; c++) begin
            cnt = 0;
            for (int h = 0; h < B_HID; h++) begin
                if (hid[h] == B_W1[c*B_HID + h]) cnt++;
            end
            if (cnt > best) begin
                best = cnt;
                pred = c;
            end
        end
        scr = best;
    endfunction

    // Offer one vector to small instance k, then return the cycles until out_valid (capped at 200).
    task automatic small_infer(input int k, input logic [15:0] f, output int lat);
        @(negedge clk);
        s_feat[k]      = f;
        s_in_valid[k]  = 1'b1;
        s_out_ready[k] = 1'b0;
        @(posedge clk); #1;
        s_in_valid[k] = 1'b0;
        s_feat[k]     = ~f;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (s_out_valid[k]) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({s_in_ready[k], s_out_valid[k], s_pred[k], s_score[k]} !== {1'b1, 1'b0, 2'd0, 3'd0}) begin
                errors++;
                $display("FAIL reset_small%0d got rdy=%b ov=%b pred=%0d score=%0d want rdy=1 ov=0 pred=0 score=0",
                         k, s_in_ready[k], s_out_valid[k], s_pred[k], s_score[k]);
            end
            checks++;
            if ({b_in_ready[k], b_out_valid[k], b_pred[k], b_score[k]} !== {1'b1, 1'b0, 3'd0, 6'd0}) begin
                errors++;
                $display("FAIL reset_big%0d got rdy=%b ov=%b pred=%0d score=%0d want rdy=1 ov=0 pred=0 score=0",
                         k, b_in_ready[k], b_out_valid[k], b_pred[k], b_score[k]);
            end
        end
    endtask

    // Shared checks for one directed small inference and its release.
    task automatic run_small_case(input string name, input int k, input logic [15:0] f,
                                  input int exp_pred, input int exp_score);
        int lat;
        small_infer(k, f, lat);
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL %s_latency got %0d want 6", name, lat);
        end
        checks++;
        if (int'(s_pred[k]) !== exp_pred || int'(s_score[k]) !== exp_score) begin
            errors++;
            $display("FAIL %s_result got pred=%0d score=%0d want pred=%0d score=%0d",
                     name, s_pred[k], s_score[k], exp_pred, exp_score);
        end
        s_out_ready[k] = 1'b1;
        @(posedge clk); #1;
        s_out_ready[k] = 1'b0;
        checks++;
        if ({s_out_valid[k], s_in_ready[k]} !== 2'b01) begin
            errors++;
            $display("FAIL %s_release got ov=%b rdy=%b want ov=0 rdy=1", name, s_out_valid[k], s_in_ready[k]);
        end
    endtask

    task automatic test_tie_break();
        run_small_case("tie_break", 0, 16'($urandom), 1, 4);
    endtask

    task automatic test_all_negative();
        run_small_case("all_negative", 1, 16'h0005, 0, 4);
    endtask

    task automatic test_non_dividing();
        run_small_case("non_dividing", 2, 16'($urandom), 1, 4);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        small_infer(0, 16'h1234, lat);
        checks++;
        if (lat !== 6 || s_pred[0] !== 2'd1 || s_score[0] !== 3'd4) begin
            errors++;
            $display("FAIL bp_first got lat=%0d pred=%0d score=%0d want lat=6 pred=1 score=4", lat, s_pred[0], s_score[0]);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            s_in_valid[0] = (i == 3 || i == 4);
            s_feat[0]     = 16'h0000;
            @(posedge clk); #1;
            if ({s_out_valid[0], s_in_ready[0], s_pred[0], s_score[0]} !== {1'b1, 1'b0, 2'd1, 3'd4}) bad++;
        end
        s_in_valid[0] = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
        end
        s_out_ready[0] = 1'b1;
        @(posedge clk); #1;
        s_out_ready[0] = 1'b0;
        checks++;
        if ({s_out_valid[0], s_in_ready[0]} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release got ov=%b rdy=%b want ov=0 rdy=1", s_out_valid[0], s_in_ready[0]);
        end
        @(posedge clk); #1;
        checks++;
        if ({s_out_valid[0], s_in_ready[0]} !== 2'b01) begin
            errors++;
            $display("FAIL bp_no_accept got ov=%b rdy=%b want ov=0 rdy=1", s_out_valid[0], s_in_ready[0]);
        end
    endtask

    task automatic test_reset_abort();
        int rises;
        @(negedge clk);
        s_feat[0]     = 16'hA5A5;
        s_in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_in_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({s_in_ready[0], s_out_valid[0]} !== 2'b10) begin
            errors++;
            $display("FAIL abort_after_reset got rdy=%b ov=%b want rdy=1 ov=0", s_in_ready[0], s_out_valid[0]);
        end
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_out_valid[0] !== 1'b0) rises++;
        end
        checks++;
        if (rises !== 0) begin
            errors++;
            $display("FAIL abort_no_result got %0d valid cycles want 0", rises);
        end
        run_small_case("abort_next", 0, 16'h0F0F, 1, 4);
    endtask

    task automatic test_random_lane(input int k);
        logic [B_FW-1:0] f;
        int exp_pred, exp_score, exp_lat, lat, wait_cyc;
        logic rdy;
        exp_lat = (B_HID + int'(B_PAR[k]) - 1) / int'(B_PAR[k]) + B_CLS + 1;
        for (int n = 0; n < N_VEC; n++) begin
            for (int w = 0; w < B_FW / 32; w++) f[w*32 +: 32] = $urandom;
            ref_model(f, exp_pred, exp_score);
            @(negedge clk);
            b_feat[k]     = f;
            b_in_valid[k] = 1'b1;
            checks++;
            if (b_in_ready[k] !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_in_ready vec %0d got %b want 1", k, n, b_in_ready[k]);
            end
            @(posedge clk); #1;
            b_in_valid[k] = 1'b0;
            for (int w = 0; w < B_FW / 32; w++) b_feat[k][w*32 +: 32] = $urandom;
            lat = 0;
            while (lat < 200) begin
                @(posedge clk); #1;
                lat++;
                if (b_out_valid[k]) break;
            end
            checks++;
            if (lat !== exp_lat || int'(b_pred[k]) !== exp_pred || int'(b_score[k]) !== exp_score) begin
                errors++;
                $display("FAIL rand%0d_result vec %0d got lat=%0d pred=%0d score=%0d want lat=%0d pred=%0d score=%0d",
                         k, n, lat, b_pred[k], b_score[k], exp_lat, exp_pred, exp_score);
            end
            wait_cyc = 0;
            rdy      = 1'b0;
            while (!rdy && wait_cyc < 50) begin
                rdy = ($urandom_range(0, 3) != 0);
                b_out_ready[k] = rdy;
                @(posedge clk); #1;
                wait_cyc++;
                if (!rdy) begin
                    checks++;
                    if (b_out_valid[k] !== 1'b1 || int'(b_pred[k]) !== exp_pred || int'(b_score[k]) !== exp_score) begin
                        errors++;
                        $display("FAIL rand%0d_hold vec %0d got ov=%b pred=%0d score=%0d", k, n, b_out_valid[k], b_pred[k], b_score[k]);
                    end
                end
            end
            b_out_ready[k] = 1'b0;
            checks++;
            if ({b_out_valid[k], b_in_ready[k]} !== 2'b01) begin
                errors++;
                $display("FAIL rand%0d_release vec %0d got ov=%b rdy=%b want ov=0 rdy=1", k, n, b_out_valid[k], b_in_ready[k]);
            end
        end
    endtask

    task automatic test_random();
        fork
            test_random_lane(0);
            test_random_lane(1);
            test_random_lane(2);
        join
    endtask

    initial begin
        s_feat      = '0;
        s_in_valid  = '0;
        s_out_ready = '0;
        b_feat      = '0;
        b_in_valid  = '0;
        b_out_ready = '0;
        test_reset();
        test_tie_break();
        test_all_negative();
        test_backpressure();
        test_reset_abort();
        test_non_dividing();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog simulation did not complete within 200000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
